// File: rtl/radix4_commutator_if.sv
// -----------------------------------------------------------------------------
// radix4_commutator_if
// Bus bundle for the radix-4 delay commutator.
//   in_valid  : beat accepted on the rising edge when 1
//   in_data   : four input lanes, lane k at [k*DATA_W +: DATA_W]
//   in_sop    : frame-start marker (only when COMMUT_SOP_SYNC_EN is defined)
//   out_valid : out_data holds a new beat (registered)
//   out_data  : four transposed lanes, same packing as in_data
//   out_sel   : sub-block index of the current output beat
//   out_sop   : first beat of an output frame
// Modports: master = upstream/driver side, slave = commutator side.
//
// Handshake: a beat moves on every rising edge where in_valid=1. There is no
// back-pressure. out_valid is a one-cycle qualifier for each new output beat,
// and out_data/out_sel/out_sop hold their values while out_valid is 0.
// -----------------------------------------------------------------------------
interface radix4_commutator_if #(
  parameter int DATA_W = 32
);
  logic                  in_valid;
  logic [4*DATA_W-1:0]   in_data;
`ifdef COMMUT_SOP_SYNC_EN
  logic                  in_sop;
`endif
  logic                  out_valid;
  logic [4*DATA_W-1:0]   out_data;
  logic [1:0]            out_sel;
  logic                  out_sop;

  modport master (
    output in_valid,
    output in_data,
`ifdef COMMUT_SOP_SYNC_EN
    output in_sop,
`endif
    input  out_valid,
    input  out_data,
    input  out_sel,
    input  out_sop
  );

  modport slave (
    input  in_valid,
    input  in_data,
`ifdef COMMUT_SOP_SYNC_EN
    input  in_sop,
`endif
    output out_valid,
    output out_data,
    output out_sel,
    output out_sop
  );
endinterface

// File: rtl/radix4_commutator.sv
// -----------------------------------------------------------------------------
// radix4_commutator
// Radix-4 delay commutator: a 4x4 block transpose over frames of 4*L beats.
// Output frame position p = i*L+o carries, on lane j, input lane i from input
// position j*L+o of the same frame. Latency is 3L accepted beats; the output
// for position m is loaded on the edge that accepts beat m+3L.
//
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : radix4_commutator_if.slave (in_valid/in_data[/in_sop],
//           out_valid/out_data/out_sel/out_sop)
//
// Optional feature macro: COMMUT_SOP_SYNC_EN -- adds in_sop frame resync.
//
// Storage is one circular buffer of 6L four-lane words. Every sample needed
// for an output is addressed by its age in accepted beats:
//   age = (3 + i - j) * L    (0 .. 6L)
// Age 0 is the beat being accepted this edge (i=0, j=3). Age 6L lands on the
// slot being overwritten this edge; the read sees its old contents.
// -----------------------------------------------------------------------------
module radix4_commutator #(
  parameter int DATA_W = 32,
  parameter int L      = 4
) (
  input  logic                clk,
  input  logic                reset,
  radix4_commutator_if.slave  bus
);
  localparam int FRAME = 4 * L;
  localparam int CW    = $clog2(FRAME);
  localparam int DEPTH = 6 * L;
  localparam int AW    = $clog2(DEPTH);
  localparam int FW    = $clog2(3 * L + 1);

  localparam logic [CW-1:0] L_OFS    = CW'(L);
  localparam logic [FW-1:0] FILL_MAX = FW'(3 * L);
  localparam logic [AW-1:0] WP_LAST  = AW'(DEPTH - 1);

  logic [4*DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wp;
  logic [CW-1:0]       cnt;
  logic [FW-1:0]       fill;

  logic [CW-1:0]       pos;
  logic [1:0]          sel;
  logic [4*DATA_W-1:0] next_data;
  logic                resync;

  logic                out_valid_q;
  logic [4*DATA_W-1:0] out_data_q;
  logic [1:0]          out_sel_q;
  logic                out_sop_q;

`ifdef COMMUT_SOP_SYNC_EN
  // A marker on an already-aligned frame start is a no-op.
  assign resync = bus.in_sop && (cnt != '0);
`else
  assign resync = 1'b0;
`endif

  // Output frame position m mod 4L = (cnt - 3L) mod 4L = cnt + L (wrapping).
  // Since 4L is a power of two, the top two bits of that are i.
  always_comb begin
    pos       = cnt + L_OFS;
    sel       = pos[CW-1 -: 2];
    next_data = '0;
    for (int j = 0; j < 4; j++) begin
      int                  age;
      int                  addr;
      logic [4*DATA_W-1:0] word;
      age  = (3 + int'(sel) - j) * L;
      addr = int'(wp) - age;
      if (addr < 0) addr = addr + DEPTH;
      word = (age == 0) ? bus.in_data : mem[addr[AW-1:0]];
      next_data[j*DATA_W +: DATA_W] = word[int'(sel)*DATA_W +: DATA_W];
    end
  end

  // Buffer contents are don't-care after reset; the fill counter keeps them
  // from being emitted until they have been rewritten.
  always_ff @(posedge clk) begin
    if (bus.in_valid) mem[wp] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp          <= '0;
      cnt         <= '0;
      fill        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
      out_sop_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.in_valid) begin
        wp <= (wp == WP_LAST) ? '0 : wp + AW'(1);
        if (resync) begin
          // This beat is t=0 of a new frame; the partial frame is dropped.
          cnt  <= CW'(1);
          fill <= FW'(1);
        end else begin
          cnt <= cnt + CW'(1);
          if (fill != FILL_MAX) begin
            fill <= fill + FW'(1);
          end else begin
            out_valid_q <= 1'b1;
            out_data_q  <= next_data;
            out_sel_q   <= sel;
            out_sop_q   <= (pos == '0);
          end
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_sop   = out_sop_q;
endmodule

// File: tb/tb_radix4_commutator.sv
// -----------------------------------------------------------------------------
// tb_radix4_commutator
// Drives two commutators in lockstep: A (DATA_W=32, L=4) and B (DATA_W=16,
// L=1). The reference model keeps every beat accepted since the last
// alignment and computes each expected output straight from the transpose
// rule: output m takes, on lane j, input lane i of beat f*4L + j*L + o.
// Define COMMUT_SOP_SYNC_EN to also exercise frame resync.
// -----------------------------------------------------------------------------
module tb_radix4_commutator;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  radix4_commutator_if #(.DATA_W(32)) bus_a ();
  radix4_commutator_if #(.DATA_W(16)) bus_b ();

  radix4_commutator #(.DATA_W(32), .L(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  radix4_commutator #(.DATA_W(16), .L(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: accepted-beat history per DUT (lanes in 32-bit slots) and
  // the expected registered outputs.
  logic [127:0] hist_a[$];
  logic [127:0] hist_b[$];
  logic         exp_valid [2];
  logic [127:0] exp_data  [2];
  logic [1:0]   exp_sel   [2];
  logic         exp_sop   [2];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lval(input int w);
    return (w != 0) ? 1 : 4;
  endfunction

  function automatic int hsize(input int w);
    return (w != 0) ? hist_b.size() : hist_a.size();
  endfunction

  function automatic logic [127:0] hget(input int w, input int idx);
    return (w != 0) ? hist_b[idx] : hist_a[idx];
  endfunction

  function automatic logic [127:0] pk4(input int l0, input int l1, input int l2, input int l3);
    return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
  endfunction

  function automatic logic [127:0] widen_b(input logic [63:0] d);
    return {16'b0, d[63:48], 16'b0, d[47:32], 16'b0, d[31:16], 16'b0, d[15:0]};
  endfunction

  function automatic logic [127:0] ref_word(input int w, input int n);
    int l, fr, m, f, p, i, o;
    logic [127:0] r, src;
    l  = lval(w);
    fr = 4 * l;
    m  = n - 3 * l;
    f  = m / fr;
    p  = m % fr;
    i  = p / l;
    o  = p % l;
    r  = '0;
    for (int j = 0; j < 4; j++) begin
      src = hget(w, f * fr + j * l + o);
      r[j*32 +: 32] = src[i*32 +: 32];
    end
    return r;
  endfunction

  task automatic model_clear();
    hist_a.delete();
    hist_b.delete();
    for (int w = 0; w < 2; w++) begin
      exp_valid[w] = 1'b0;
      exp_data[w]  = '0;
      exp_sel[w]   = 2'd0;
      exp_sop[w]   = 1'b0;
    end
  endtask

  task automatic model_beat(input int w, input bit v, input bit s, input logic [127:0] word);
    int l, fr, n, m;
    l  = lval(w);
    fr = 4 * l;
    exp_valid[w] = 1'b0;
    if (v) begin
      if (s && (hsize(w) % fr != 0)) begin
        if (w != 0) hist_b.delete(); else hist_a.delete();
      end
      if (w != 0) hist_b.push_back(word); else hist_a.push_back(word);
      n = hsize(w) - 1;
      if (n >= 3 * l) begin
        m = n - 3 * l;
        exp_valid[w] = 1'b1;
        exp_data[w]  = ref_word(w, n);
        exp_sel[w]   = 2'((m % fr) / l);
        exp_sop[w]   = ((m % fr) == 0);
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_a_valid"}, 128'(bus_a.out_valid), 128'(exp_valid[0]));
    check({tag, "_a_data"},  bus_a.out_data, exp_data[0]);
    check({tag, "_a_sel"},   128'(bus_a.out_sel), 128'(exp_sel[0]));
    check({tag, "_a_sop"},   128'(bus_a.out_sop), 128'(exp_sop[0]));
    check({tag, "_b_valid"}, 128'(bus_b.out_valid), 128'(exp_valid[1]));
    check({tag, "_b_data"},  widen_b(bus_b.out_data), exp_data[1]);
    check({tag, "_b_sel"},   128'(bus_b.out_sel), 128'(exp_sel[1]));
    check({tag, "_b_sop"},   128'(bus_b.out_sop), 128'(exp_sop[1]));
  endtask

  // One clock: drive at the falling edge, check 1 time unit after the rising
  // edge. Pattern data is lane k at frame position t = k*100 + t.
  task automatic step(input bit v, input bit s_in, input bit rnd, input string tag);
    logic [127:0] wa, wb;
    int pa, pb;
    bit s;
`ifdef COMMUT_SOP_SYNC_EN
    s = s_in;
`else
    s = 1'b0;
    if (s_in) s = 1'b0;
`endif
    pa = (v && s) ? 0 : hist_a.size() % 16;
    pb = (v && s) ? 0 : hist_b.size() % 4;
    for (int k = 0; k < 4; k++) begin
      if (rnd) begin
        wa[k*32 +: 32] = $urandom;
        wb[k*32 +: 32] = {16'b0, 16'($urandom)};
      end else begin
        wa[k*32 +: 32] = 32'(k * 100 + pa);
        wb[k*32 +: 32] = 32'(k * 100 + pb);
      end
    end
    @(negedge clk);
    reset          = 1'b0;
    bus_a.in_valid = v;
    bus_a.in_data  = wa;
    bus_b.in_valid = v;
    bus_b.in_data  = {wb[111:96], wb[79:64], wb[47:32], wb[15:0]};
`ifdef COMMUT_SOP_SYNC_EN
    bus_a.in_sop = s;
    bus_b.in_sop = s;
`endif
    @(posedge clk);
    #1;
    model_beat(0, v, s, wa);
    model_beat(1, v, s, wb);
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset          = 1'b1;
    bus_a.in_valid = 1'b0;
    bus_b.in_valid = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    check_outputs(tag);
  endtask

  initial begin
    reset          = 1'b1;
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = '0;
    bus_b.in_valid = 1'b0;
    bus_b.in_data  = '0;
`ifdef COMMUT_SOP_SYNC_EN
    bus_a.in_sop = 1'b0;
    bus_b.in_sop = 1'b0;
`endif
    model_clear();
    do_reset("rst0");
    do_reset("rst1");

    // Continuous frames with the pattern stimulus.
    for (int b = 0; b < 30; b++) begin
      step(1'b1, 1'b0, 1'b0, "cont");
      if (b == 2)  check("b_pre_valid", 128'(bus_b.out_valid), 128'(0));
      if (b == 3) begin
        check("b_first_valid", 128'(bus_b.out_valid), 128'(1));
        check("b_first_data", widen_b(bus_b.out_data), pk4(0, 1, 2, 3));
      end
      if (b == 4)  check("b_second_data", widen_b(bus_b.out_data), pk4(100, 101, 102, 103));
      if (b == 11) check("a_pre_valid", 128'(bus_a.out_valid), 128'(0));
      if (b == 12) begin
        check("a_first_valid", 128'(bus_a.out_valid), 128'(1));
        check("a_m0_data", bus_a.out_data, pk4(0, 4, 8, 12));
        check("a_m0_sop", 128'(bus_a.out_sop), 128'(1));
        check("a_m0_sel", 128'(bus_a.out_sel), 128'(0));
      end
      if (b == 17) begin
        check("a_m5_data", bus_a.out_data, pk4(101, 105, 109, 113));
        check("a_m5_sel", 128'(bus_a.out_sel), 128'(1));
      end
      if (b == 27) check("a_m15_data", bus_a.out_data, pk4(303, 307, 311, 315));
      if (b == 28) begin
        check("a_m16_valid", 128'(bus_a.out_valid), 128'(1));
        check("a_m16_sop", 128'(bus_a.out_sop), 128'(1));
      end
    end

    // Idle gap mid-frame, then resume.
    for (int b = 0; b < 3; b++) step(1'b0, 1'b0, 1'b0, "idle");
    for (int b = 0; b < 12; b++) step(1'b1, 1'b0, 1'b0, "resume");

    // Reset at beat 7 of frame 2, then restart.
    do_reset("rst_pre");
    for (int b = 0; b < 23; b++) step(1'b1, 1'b0, 1'b0, "pre_mid");
    do_reset("rst_mid");
    for (int b = 0; b < 13; b++) step(1'b1, 1'b0, 1'b0, "restart");
    check("restart_a_valid", 128'(bus_a.out_valid), 128'(1));
    check("restart_a_data", bus_a.out_data, pk4(0, 4, 8, 12));

`ifdef COMMUT_SOP_SYNC_EN
    // Resync at beat 6.
    do_reset("rst_sop");
    for (int b = 0; b < 6; b++) step(1'b1, 1'b0, 1'b0, "sop_pre");
    step(1'b1, 1'b1, 1'b0, "sop_mark");
    for (int b = 0; b < 11; b++) step(1'b1, 1'b0, 1'b0, "sop_fill");
    check("sop_fill_valid", 128'(bus_a.out_valid), 128'(0));
    step(1'b1, 1'b0, 1'b0, "sop_first");
    check("sop_first_valid", 128'(bus_a.out_valid), 128'(1));
    check("sop_first_data", bus_a.out_data, pk4(0, 4, 8, 12));
    check("sop_first_sop", 128'(bus_a.out_sop), 128'(1));
`endif

    // Randomized traffic with gaps (and occasional resync markers).
    do_reset("rst_rnd");
    for (int b = 0; b < 400; b++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 30) == 0, 1'b1, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/radix4_commutator.md
# radix4_commutator

Parametrised radix-4 delay commutator for the pipelined radix-4 FFT datapath, placed between a butterfly stage and the next twiddle/butterfly stage. It takes four parallel lanes and performs a 4×4 block transpose over frames of 4·L beats, so the next butterfly sees the correct operand quadruples. It generalises the fixed stage-2 commutator to any stride L and data width. It adds valid-qualified flow with freeze-on-idle, a frame-start marker output and optional frame resynchronisation.

## Interface
Parameters:
- DATA_W, 32: bits per lane sample (real or imaginary part; one instance per part).
- L, 4: stride/sub-block length in beats. Power of two, ≥1. Frame = 4·L beats.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  beat accepted on this edge when 1.
- in_data  in  4·DATA_W  lane k at bits [k·DATA_W +: DATA_W].
- in_sop  in  1  frame-start marker. Present only with COMMUT_SOP_SYNC_EN.
- out_valid  out  1  out_data holds a new beat (registered).
- out_data  out  4·DATA_W  transposed lanes, same packing.
- out_sel  out  2  sub-block index i of the current output beat (0..3), for the downstream butterfly/twiddle select.
- out_sop  out  1  1 on the first beat of each output frame.

## Operation
- Beat counter cnt (log2(4L) bits) increments on each accepted beat and wraps 4L−1→0. Input position t = cnt: block b = t/L, offset o = t%L.
- Transpose rule: output frame position p = i·L+o, lane j carries input lane i from the same frame at position j·L+o.
- Fill counter tracks accepted beats since reset or resync and saturates at 3L.
- On an edge where in_valid=1 and the fill has reached 3L (this beat being the 3L-th or later), output registers load beat m = n−3L, where n is the global accepted-beat index. out_valid goes to 1.
- The input beat accepted on the same edge is usable for output. The case needing this is j=3 with i=0.
- Edges with in_valid=0: out_valid←0. out_data, out_sel and out_sop hold. Internal state freezes; no beat is lost or duplicated.
- out_sel = i = (m mod 4L)/L. out_sop = (m mod 4L == 0), qualified by out_valid.
- Storage: per-lane delay memory, depth ≤ 6L words of DATA_W. Data is passed bit-exact; no arithmetic.
- Reset, including mid-frame: cnt=0, fill=0, out_valid=0, out_sop=0, out_sel=0, out_data=0. Memory contents are don't-care and are never emitted before a refill.

## Timing
- Latency: exactly 3L accepted beats. The output for input frame position t appears on the edge accepting beat t+3L.
- Throughput: one beat per clock, sustained.
- With continuous in_valid from reset deassertion, the first out_valid is registered on the edge accepting beat index 3L (L=4: 13th beat). out_valid then stays 1.
- Steady state at frame wrap: no bubbles; out_sop pulses every 4L valid outputs.

## Configuration
- COMMUT_SOP_SYNC_EN defined:
  - in_sop exists. When in_valid=1 and in_sop=1, the beat is taken as t=0 of a new frame: cnt←1 after the edge and fill←1.
  - out_valid is suppressed until 3L beats of the new frame are accepted. A partial previous frame is discarded.
  - in_sop with in_valid=0 is ignored. in_sop at t=0 of an already-aligned frame causes no flush.
- COMMUT_SOP_SYNC_EN undefined: no in_sop port. Alignment comes purely from beat count since reset.

## Test plan
Common stimulus: L=4, DATA_W=32, input lane k at position t = k·100+t.
- Continuous frames:
  - First out_valid on the 13th accepted beat.
  - m=0 lanes = 0,4,8,12; out_sop=1; out_sel=0.
  - m=5 lanes = 101,105,109,113; out_sel=1.
  - m=15 lanes = 303,307,311,315.
  - Second frame follows with no gap.
- in_valid low for 3 cycles mid-frame: out_valid=0 and outputs hold for 3 cycles; the sequence then resumes with no missing or repeated beat.
- reset pulsed at beat 7 of frame 2: next cycle all outputs are 0. After restart, the first out_valid comes again on the 13th beat with lanes 0,4,8,12.
- L=1, DATA_W=16: frame of 4 beats; first out_valid on the 4th beat; output lanes = 0,1,2,3 then 100,101,102,103.
- With COMMUT_SOP_SYNC_EN: assert in_sop at beat 6. No out_valid until 12 beats after it. The first output is lanes 0,4,8,12 relative to the new frame, with out_sop=1.
